// File: rtl/aes_sd_pkg.sv
// Shared definitions for the AES/SDRAM datapath: mode encodings, FSM states, bus widths.
// Used by both the result writer and the read/AES stage.
package aes_sd_pkg;

  localparam int DATA_W = 16;
  localparam int BLK_W  = 128;
  localparam int WORDS  = BLK_W / DATA_W;
  localparam int IDX_W  = $clog2(WORDS);

  typedef logic [1:0] mode_t;
  localparam mode_t MODE_ENC = 2'b10;
  localparam mode_t MODE_DEC = 2'b01;
  localparam mode_t MODE_BAD = 2'b11;

  localparam logic [DATA_W-1:0] TERM_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_SPACE = 3'd1,
    S_GAP        = 3'd2,
    S_ISSUE      = 3'd3,
    S_TERM       = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  function automatic logic mode_legal(mode_t m);
    return (m == MODE_ENC) || (m == MODE_DEC);
  endfunction

endpackage

// File: rtl/aes_result_writer_if.sv
// Block-in / FIFO-out bundle of the result writer; slave = writer, master = its environment.
// Signal names follow the engine's established top-level port names.
interface aes_result_writer_if;
  import aes_sd_pkg::*;

  logic              iBLK_VALID;
  logic              oBLK_READY;
  logic [BLK_W-1:0]  iBLK_DATA;
  mode_t             iMODE;
  logic [15:0]       iWriteUse;
  logic              iSDRAM_write;
  logic              oWrite;
  logic [DATA_W-1:0] oWritedata;
  logic [1:0]        oDONE;
  logic [19:0]       oBlkCount;
  logic [2:0]        oState;

  modport slave (
    input  iBLK_VALID, iBLK_DATA, iMODE, iWriteUse, iSDRAM_write,
    output oBLK_READY, oWrite, oWritedata, oDONE, oBlkCount, oState
  );

  modport master (
    output iBLK_VALID, iBLK_DATA, iMODE, iWriteUse, iSDRAM_write,
    input  oBLK_READY, oWrite, oWritedata, oDONE, oBlkCount, oState
  );

endinterface

// File: rtl/aes_word_serializer.sv
// Holds one 128-bit block and presents it 16 bits at a time, LSW first; word valid the cycle after load.
// No backpressure of its own: advances only when the owner pulses shift.
module aes_word_serializer
  import aes_sd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BLK_W-1:0]  blk,
  input  logic              shift,
  output logic [DATA_W-1:0] word,
  output logic              last
);

  logic [BLK_W-1:0] sreg;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load) begin
      sreg <= blk;
      idx  <= '0;
    end else if (shift) begin
      sreg <= {{DATA_W{1'b0}}, sreg[BLK_W-1:DATA_W]};
      idx  <= idx + IDX_W'(1);
    end
  end

  assign word = sreg[DATA_W-1:0];
  assign last = (idx == IDX_W'(WORDS - 1));

endmodule

// File: rtl/aes_result_writer.sv
// Serialises accepted AES blocks into 8 paced FIFO write strobes; first strobe GAP+1 cycles after capture.
// Blocks refused outside IDLE; a block starts only with FIFO below FIFO_HI and the SDRAM side idle.
module aes_result_writer
  import aes_sd_pkg::*;
#(
  parameter int unsigned GAP          = 8,
  parameter logic [15:0] FIFO_HI      = 16'h0100,
  parameter logic [19:0] BLOCK_TARGET = 20'h10000
)
(
  input  logic iCLK,
  input  logic iRST_n,
  aes_result_writer_if.slave bus
);

  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_t            state, state_d;
  logic [7:0]        cnt, cnt_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic [1:0]        done_q, done_d;
  logic [19:0]       blkcnt_q, blkcnt_d;
  mode_t             mode_q, mode_d;
  logic              illegal_q, illegal_d;

  logic              load, shift, ser_last;
  logic [DATA_W-1:0] ser_word;

  aes_word_serializer u_ser (
    .clk   (iCLK),
    .rst_n (iRST_n),
    .load  (load),
    .blk   (bus.iBLK_DATA),
    .shift (shift),
    .word  (ser_word),
    .last  (ser_last)
  );

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      ready_q   <= 1'b0;
      done_q    <= 2'b00;
      blkcnt_q  <= '0;
      mode_q    <= 2'b00;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      blkcnt_q  <= blkcnt_d;
      mode_q    <= mode_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    write_d   = 1'b0;
    wdata_d   = wdata_q;
    done_d    = done_q;
    blkcnt_d  = blkcnt_q;
    mode_d    = mode_q;
    illegal_d = illegal_q;
    load      = 1'b0;
    shift     = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.iBLK_VALID && ready_q) begin
          load    = 1'b1;
          mode_d  = bus.iMODE;
          state_d = S_WAIT_SPACE;
          if (!mode_legal(bus.iMODE)) illegal_d = 1'b1;
        end
      end
      // Space is checked once per block; the 8 words then go out regardless of fill level.
      S_WAIT_SPACE: begin
        if ((bus.iWriteUse < FIFO_HI) && !bus.iSDRAM_write) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          write_d = 1'b1;
          wdata_d = ser_word;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_ISSUE: begin
        if (!ser_last) begin
          shift   = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          blkcnt_d = blkcnt_q + 20'd1;
          state_d  = (blkcnt_d == BLOCK_TARGET) ? S_TERM : S_IDLE;
        end
      end
      S_TERM: begin
        wdata_d = TERM_WORD;
        done_d  = illegal_q ? MODE_BAD : mode_q;
        state_d = S_DONE;
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_d = (state_d == S_IDLE) && (done_d == 2'b00);

  assign bus.oBLK_READY = ready_q;
  assign bus.oWrite     = write_q;
  assign bus.oWritedata = wdata_q;
  assign bus.oDONE      = done_q;
  assign bus.oBlkCount  = blkcnt_q;
  assign bus.oState     = state;

endmodule
